hxmpp_request_sequencer: RTL and testbench
==========================================

Name: hxmpp_request_sequencer

Overview:
- Upstream front end of the HXMPP memory stack. Buffers incoming hits (SSID plus hit info) and per-event read requests in two small FIFOs.
- Drives the single-cycle write/writeSSID/writeHitInfo and read/readSSID strobes of hxmpp.
- Enforces the event ordering: all writes of an event issue first, then a fixed drain gap for the HNM→HCM→HIM pipeline, then the reads.
- Reads are throttled by an outstanding-read credit counter that is returned on readFinished.

Parameters:
- SSID_W, 8, width of SSID / HCM row index
- HITINFO_W, 8, width of hit info word
- HIT_FIFO_DEPTH, 8, hit FIFO entries (power of 2)
- RD_FIFO_DEPTH, 4, read-request FIFO entries (power of 2)
- DRAIN_CYCLES, 6, idle cycles between last write and first read
- MAX_OUTSTANDING, 4, max issued reads without readFinished (≤ hxmpp QUEUESIZE)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- hit_valid  in  1  hit offered
- hit_ready  out  1  hit FIFO not full
- hit_ssid  in  SSID_W  hit SSID
- hit_info  in  HITINFO_W  hit info
- hit_last  in  1  marks last hit of event
- rd_valid  in  1  read request offered
- rd_ready  out  1  read FIFO not full
- rd_ssid  in  SSID_W  SSID to read
- rd_last  in  1  marks last read of event
- write  out  1  write strobe to hxmpp
- writeSSID  out  SSID_W  SSID for write
- writeHitInfo  out  HITINFO_W  hit info for write
- read  out  1  read strobe to hxmpp
- readSSID  out  SSID_W  SSID for read
- readFinished  in  1  hxmpp read return pulse
- event_done  out  1  one-cycle pulse: event fully written and read back
- busy  out  1  state ≠ IDLE
- credit_err  out  1  sticky: readFinished seen with zero outstanding

Behaviour:
- Reset (async assert, sync release): FIFOs empty, state IDLE, counters 0. All outputs 0 except hit_ready=1 and rd_ready=1.
- FIFOs:
  - Push on valid&&ready. ready = !full, based on current occupancy only; a same-cycle pop does not raise ready.
  - Pop only when non-empty. Each entry stores its last flag.
  - Pointers wrap modulo depth; count is $clog2(depth)+1 bits.
- All strobes and data outputs are registered; each strobe is high for exactly one cycle per issued command. write and read are never high in the same cycle.
- IDLE: hit FIFO non-empty → WRITE.
- WRITE:
  - Each cycle with hit FIFO non-empty: pop and issue write next cycle, back-to-back allowed.
  - Popped entry with last=1 → DRAIN; drain counter loads DRAIN_CYCLES.
  - FIFO empty without last: hold and issue nothing.
  - Read requests keep buffering in this state but are not issued.
- DRAIN: counter decrements each cycle; at 0 → READ. First read strobe appears DRAIN_CYCLES+1 cycles after the last write strobe.
- READ:
  - Pop and issue read when rd FIFO non-empty and outstanding < MAX_OUTSTANDING.
  - Popped entry with last=1 → WAIT.
  - Hits arriving in this state buffer only.
- WAIT: when outstanding==0 → event_done pulse, state IDLE. IDLE re-enters WRITE the following cycle if hits are pending.
- outstanding counter:
  - +1 on read issue, −1 on readFinished; both in the same cycle → unchanged.
  - readFinished with outstanding==0: counter stays 0, credit_err set until reset.
- readFinished is accepted in any state.
- Reset mid-operation: immediate abort. Buffered entries are discarded and no further strobes are issued.

Decomposition:
- Shared package hxmpp_pkg holds:
  - the state enum (IDLE, WRITE, DRAIN, READ, WAIT)
  - default widths SSID_W/HITINFO_W, matching ROWINDEXBITS_HCM/HITINFOBITS
  - DRAIN_CYCLES and MAX_OUTSTANDING defaults, tied to QUEUESIZE
- One sub-module: seq_fifo (parameterised width/depth, last-flag bit, full/empty/count). Instantiated twice.

Test Plan:
- 3 hits (SSID 5,9,5, last on third), then 2 reads (5 and 9, last on second) → 3 consecutive write pulses carrying SSIDs 5,9,5; 6 idle cycles; 2 read pulses. With readFinished returned after both reads, event_done pulses once.
- Reads offered before and during the hits → no read strobe until DRAIN completes; read order is preserved.
- 6 reads issued with readFinished held low → exactly 4 read strobes, then stall. One readFinished pulse → the 5th read issues on the next eligible cycle.
- Push 8 hits while the sequencer is stalled (no last flag) → hit_ready=0 after the 8th; a 9th offer is not accepted and is not lost upstream.
- readFinished pulse in IDLE with outstanding 0 → credit_err=1 and stays set; the counter does not underflow.
- Assert reset during DRAIN with 2 reads buffered → write/read stay 0, busy=0, hit_ready=rd_ready=1. Afterwards a fresh 1-hit/1-read event completes normally.

Source files
------------

// File: rtl/hxmpp_request_sequencer_pkg.sv
// Shared types and default sizing for the HXMPP request sequencer.
// Widths and credit depth follow the hxmpp core they front.
package hxmpp_pkg;

   localparam int ROWINDEXBITS_HCM    = 8;
   localparam int HITINFOBITS         = 8;
   localparam int QUEUESIZE           = 4;

   localparam int SSID_W_DEF          = ROWINDEXBITS_HCM;
   localparam int HITINFO_W_DEF       = HITINFOBITS;
   localparam int DRAIN_CYCLES_DEF    = 6;
   localparam int MAX_OUTSTANDING_DEF = QUEUESIZE;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_DRAIN = 3'd2,
      ST_READ  = 3'd3,
      ST_WAIT  = 3'd4
   } seq_state_t;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/hxmpp_request_sequencer_seq_fifo.sv
// Small synchronous FIFO carrying a data word plus a last flag per entry.
// Show-ahead read port: pop_data/pop_last reflect the head entry.
module seq_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     push_last,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     pop_last,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH:0]  mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign pop_data = mem[rd_ptr][WIDTH-1:0];
   assign pop_last = mem[rd_ptr][WIDTH];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= {push_last, push_data};
      end
   end

   // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hxmpp_request_sequencer.sv
// Front end of the HXMPP memory stack: buffers hits and read requests and
// issues them to hxmpp as write-all, drain, then credit-throttled reads.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no event in flight; waiting for a buffered hit
// ST_WRITE | popping hits and issuing writes until the last hit
// ST_DRAIN | fixed gap so the HNM->HCM->HIM pipeline settles
// ST_READ  | popping read requests while credits remain
// ST_WAIT  | all reads issued; waiting for every readFinished
module hxmpp_request_sequencer
   import hxmpp_pkg::*;
#(
   parameter int SSID_W          = SSID_W_DEF,
   parameter int HITINFO_W       = HITINFO_W_DEF,
   parameter int HIT_FIFO_DEPTH  = 8,
   parameter int RD_FIFO_DEPTH   = 4,
   parameter int DRAIN_CYCLES    = DRAIN_CYCLES_DEF,
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 hit_valid,
   output logic                 hit_ready,
   input  logic [SSID_W-1:0]    hit_ssid,
   input  logic [HITINFO_W-1:0] hit_info,
   input  logic                 hit_last,
   input  logic                 rd_valid,
   output logic                 rd_ready,
   input  logic [SSID_W-1:0]    rd_ssid,
   input  logic                 rd_last,
   output logic                 write,
   output logic [SSID_W-1:0]    writeSSID,
   output logic [HITINFO_W-1:0] writeHitInfo,
   output logic                 read,
   output logic [SSID_W-1:0]    readSSID,
   input  logic                 readFinished,
   output logic                 event_done,
   output logic                 busy,
   output logic                 credit_err
);

   localparam int HW = SSID_W + HITINFO_W;
   localparam int DW = cnt_w(DRAIN_CYCLES);
   localparam int OW = cnt_w(MAX_OUTSTANDING);

   seq_state_t                      state;
   logic [DW-1:0]                   drain_cnt;
   logic [OW-1:0]                   outstanding;

   logic [HW-1:0]                   hit_head;
   logic                            hit_head_last;
   logic                            hit_full;
   logic                            hit_empty;
   logic [$clog2(HIT_FIFO_DEPTH):0] hit_count;
   logic                            hit_pop;

   logic [SSID_W-1:0]               rd_head;
   logic                            rd_head_last;
   logic                            rd_full;
   logic                            rd_empty;
   logic [$clog2(RD_FIFO_DEPTH):0]  rd_count;
   logic                            rd_pop;

   logic                            fin_ok;

   seq_fifo #(
      .WIDTH (HW),
      .DEPTH (HIT_FIFO_DEPTH)
   ) u_hit_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (hit_valid),
      .push_data ({hit_ssid, hit_info}),
      .push_last (hit_last),
      .pop       (hit_pop),
      .pop_data  (hit_head),
      .pop_last  (hit_head_last),
      .full      (hit_full),
      .empty     (hit_empty),
      .count     (hit_count)
   );

   seq_fifo #(
      .WIDTH (SSID_W),
      .DEPTH (RD_FIFO_DEPTH)
   ) u_rd_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rd_valid),
      .push_data (rd_ssid),
      .push_last (rd_last),
      .pop       (rd_pop),
      .pop_data  (rd_head),
      .pop_last  (rd_head_last),
      .full      (rd_full),
      .empty     (rd_empty),
      .count     (rd_count)
   );

   assign hit_ready = !hit_full;
   assign rd_ready  = !rd_full;
   assign busy      = (state != ST_IDLE);

   assign hit_pop = (state == ST_WRITE) && !hit_empty;
   assign rd_pop  = (state == ST_READ) && !rd_empty
                    && (outstanding < OW'(MAX_OUTSTANDING));
   assign fin_ok  = readFinished && (outstanding != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         drain_cnt    <= '0;
         write        <= 1'b0;
         writeSSID    <= '0;
         writeHitInfo <= '0;
         read         <= 1'b0;
         readSSID     <= '0;
         event_done   <= 1'b0;
      end else begin
         write      <= 1'b0;
         read       <= 1'b0;
         event_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (!hit_empty) begin
                  state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (hit_pop) begin
                  write        <= 1'b1;
                  writeSSID    <= hit_head[HW-1:HITINFO_W];
                  writeHitInfo <= hit_head[HITINFO_W-1:0];
                  if (hit_head_last) begin
                     state     <= ST_DRAIN;
                     drain_cnt <= DW'(DRAIN_CYCLES);
                  end
               end
            end
            // Leaving on the 1->0 step puts the first read strobe
            // DRAIN_CYCLES+1 cycles after the last write strobe.
            ST_DRAIN: begin
               if (drain_cnt != '0) begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
               if (drain_cnt <= DW'(1)) begin
                  state <= ST_READ;
               end
            end
            ST_READ: begin
               if (rd_pop) begin
                  read     <= 1'b1;
                  readSSID <= rd_head;
                  if (rd_head_last) begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (outstanding == '0) begin
                  event_done <= 1'b1;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A stray readFinished never takes a credit it was not given.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
         credit_err  <= 1'b0;
      end else begin
         if (rd_pop && !fin_ok) begin
            outstanding <= outstanding + OW'(1);
         end else if (!rd_pop && fin_ok) begin
            outstanding <= outstanding - OW'(1);
         end
         if (readFinished && (outstanding == '0)) begin
            credit_err <= 1'b1;
         end
      end
   end

   hit_count_consistent: assert property (@(posedge clk) disable iff (reset)
      ((hit_count == '0) == hit_empty));
   rd_count_consistent: assert property (@(posedge clk) disable iff (reset)
      ((rd_count == '0) == rd_empty));

endmodule

// File: tb/tb_hxmpp_request_sequencer.sv
// Directed bench for hxmpp_request_sequencer with a queue-based reference model
// checked every cycle, plus literal expectations for the event scenarios.
module tb_hxmpp_request_sequencer;

   localparam int DRAIN = 6;
   localparam int MAXO  = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       hit_valid, hit_ready, hit_last;
   logic [7:0] hit_ssid, hit_info;
   logic       rd_valid, rd_ready, rd_last;
   logic [7:0] rd_ssid;
   logic       write, read, readFinished, event_done, busy, credit_err;
   logic [7:0] writeSSID, writeHitInfo, readSSID;

   hxmpp_request_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .hit_valid    (hit_valid),
      .hit_ready    (hit_ready),
      .hit_ssid     (hit_ssid),
      .hit_info     (hit_info),
      .hit_last     (hit_last),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_ssid      (rd_ssid),
      .rd_last      (rd_last),
      .write        (write),
      .writeSSID    (writeSSID),
      .writeHitInfo (writeHitInfo),
      .read         (read),
      .readSSID     (readSSID),
      .readFinished (readFinished),
      .event_done   (event_done),
      .busy         (busy),
      .credit_err   (credit_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] ssid;
      logic [7:0] info;
      logic       last;
   } hit_t;
   typedef struct {
      logic [7:0] ssid;
      logic       last;
   } rdreq_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   hit_t   exp_hit[$];
   rdreq_t exp_rd[$];
   int     model_out = 0;
   bit     model_err = 0;
   bit     rf_s = 0;
   bit     wr_last_seen = 0;
   bit     in_wait = 0;
   bit     exp_done = 0;
   int     last_wr_cyc = 0;

   int         wr_cyc[$];
   logic [7:0] wr_ssid[$];
   int         rd_cyc[$];
   logic [7:0] rd_ssid_log[$];
   int         done_count = 0;
   int         rf_cyc = 0;
   int         hit_acc = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Handshakes and readFinished are sampled exactly where the DUT samples them.
   always @(posedge clk) begin
      hit_t   h;
      rdreq_t r;
      cyc = cyc + 1;
      rf_s = readFinished && !reset;
      if (readFinished) rf_cyc = cyc;
      if (!reset) begin
         if (hit_valid && hit_ready) begin
            h.ssid = hit_ssid; h.info = hit_info; h.last = hit_last;
            exp_hit.push_back(h);
            hit_acc++;
         end
         if (rd_valid && rd_ready) begin
            r.ssid = rd_ssid; r.last = rd_last;
            exp_rd.push_back(r);
         end
      end
   end

   always @(negedge clk) begin
      hit_t   h;
      rdreq_t r;
      if (reset) begin
         exp_hit.delete();
         exp_rd.delete();
         model_out = 0; model_err = 0; rf_s = 0;
         wr_last_seen = 0; in_wait = 0; exp_done = 0;
         chk("rst_write", write, 0);
         chk("rst_read", read, 0);
         chk("rst_busy", busy, 0);
         chk("rst_hit_ready", hit_ready, 1);
         chk("rst_rd_ready", rd_ready, 1);
         chk("rst_credit_err", credit_err, 0);
         chk("rst_event_done", event_done, 0);
      end else begin
         if (rf_s) begin
            if (model_out > 0) model_out--;
            else model_err = 1;
         end
         chk("strobe_exclusive", write && read, 0);
         if (write) begin
            chk("write_before_event_done", wr_last_seen, 0);
            if (exp_hit.size() == 0) chk("write_unexpected", 1, 0);
            else begin
               h = exp_hit.pop_front();
               chk("write_ssid", writeSSID, h.ssid);
               chk("write_info", writeHitInfo, h.info);
               if (h.last) wr_last_seen = 1;
            end
            last_wr_cyc = cyc;
            wr_cyc.push_back(cyc);
            wr_ssid.push_back(writeSSID);
         end
         if (read) begin
            chk("read_after_all_writes", wr_last_seen, 1);
            chk("read_drain_gap", (cyc - last_wr_cyc) >= DRAIN + 1, 1);
            if (exp_rd.size() == 0) chk("read_unexpected", 1, 0);
            else begin
               r = exp_rd.pop_front();
               chk("read_ssid", readSSID, r.ssid);
               if (r.last) in_wait = 1;
            end
            model_out++;
            chk("outstanding_limit", model_out <= MAXO, 1);
            rd_cyc.push_back(cyc);
            rd_ssid_log.push_back(readSSID);
         end
         chk("event_done", event_done, exp_done);
         if (event_done) begin
            done_count++;
            chk("busy_after_done", busy, 0);
            wr_last_seen = 0;
         end
         exp_done = in_wait && (model_out == 0);
         if (exp_done) in_wait = 0;
         chk("credit_err", credit_err, model_err);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_hit(input logic [7:0] s, input logic [7:0] i, input logic l);
      int n = 0;
      hit_valid = 1'b1; hit_ssid = s; hit_info = i; hit_last = l;
      while (!hit_ready && n < 1000) begin
         tick();
         n++;
      end
      if (n == 1000) chk("push_hit_timeout", 0, 1);
      tick();
      hit_valid = 1'b0;
   endtask

   task automatic push_rd(input logic [7:0] s, input logic l);
      int n = 0;
      rd_valid = 1'b1; rd_ssid = s; rd_last = l;
      while (!rd_ready && n < 1000) begin
         tick();
         n++;
      end
      if (n == 1000) chk("push_rd_timeout", 0, 1);
      tick();
      rd_valid = 1'b0;
   endtask

   task automatic rf();
      readFinished = 1'b1;
      tick();
      readFinished = 1'b0;
   endtask

   task automatic wait_rd(input int n);
      int k = 0;
      while (rd_cyc.size() < n && k < 300) begin tick(); k++; end
      chk("wait_reads", rd_cyc.size() >= n, 1);
   endtask

   task automatic wait_wr(input int n);
      int k = 0;
      while (wr_cyc.size() < n && k < 300) begin tick(); k++; end
      chk("wait_writes", wr_cyc.size() >= n, 1);
   endtask

   task automatic wait_done(input int n);
      int k = 0;
      while (done_count < n && k < 300) begin tick(); k++; end
      chk("wait_event_done", done_count, n);
   endtask

   task automatic clear_logs();
      wr_cyc.delete(); wr_ssid.delete(); rd_cyc.delete(); rd_ssid_log.delete();
   endtask

   initial begin
      int acc0;
      reset = 1'b1;
      hit_valid = 0; hit_ssid = 0; hit_info = 0; hit_last = 0;
      rd_valid = 0; rd_ssid = 0; rd_last = 0; readFinished = 0;
      repeat (3) tick();
      chk("reset_hit_ready", hit_ready, 1);
      chk("reset_rd_ready", rd_ready, 1);
      chk("reset_busy", busy, 0);
      reset = 1'b0;
      tick();

      // Basic event: 3 hits, 2 reads
      push_hit(8'd5, 8'h11, 0);
      push_hit(8'd9, 8'h22, 0);
      push_hit(8'd5, 8'h33, 1);
      push_rd(8'd5, 0);
      push_rd(8'd9, 1);
      wait_rd(2);
      chk("t1_write_count", wr_cyc.size(), 3);
      chk("t1_wssid0", wr_ssid[0], 5);
      chk("t1_wssid1", wr_ssid[1], 9);
      chk("t1_wssid2", wr_ssid[2], 5);
      chk("t1_b2b_1", wr_cyc[1] - wr_cyc[0], 1);
      chk("t1_b2b_2", wr_cyc[2] - wr_cyc[0], 2);
      chk("t1_rssid0", rd_ssid_log[0], 5);
      chk("t1_rssid1", rd_ssid_log[1], 9);
      chk("t1_drain_gap", rd_cyc[0] - wr_cyc[2], 7);
      chk("t1_read_b2b", rd_cyc[1] - rd_cyc[0], 1);
      rf(); rf();
      wait_done(1);
      tick();
      chk("t1_idle_busy", busy, 0);
      clear_logs();

      // Reads offered before and during the hits
      fork
         begin push_rd(8'd1, 0); push_rd(8'd2, 0); push_rd(8'd3, 1); end
         begin tick(); push_hit(8'd7, 8'h44, 0); push_hit(8'd8, 8'h55, 1); end
      join
      wait_rd(3);
      chk("t2_write_count", wr_cyc.size(), 2);
      chk("t2_rssid0", rd_ssid_log[0], 1);
      chk("t2_rssid1", rd_ssid_log[1], 2);
      chk("t2_rssid2", rd_ssid_log[2], 3);
      chk("t2_drain_gap", rd_cyc[0] - wr_cyc[1], 7);
      rf(); rf(); rf();
      wait_done(2);
      clear_logs();

      // Credit stall with 6 reads, hit FIFO fills meanwhile
      fork
         push_hit(8'h21, 8'h66, 1);
         begin
            for (int i = 0; i < 6; i++) push_rd(8'h30 + 8'(i), (i == 5));
         end
      join
      wait_rd(4);
      repeat (10) tick();
      chk("t3_stall_at_4", rd_cyc.size(), 4);
      for (int i = 0; i < 8; i++) push_hit(8'h50 + 8'(i), 8'h80 + 8'(i), 0);
      chk("t4_hit_full", hit_ready, 0);
      acc0 = hit_acc;
      fork
         push_hit(8'h58, 8'h88, 1);
         begin
            repeat (5) tick();
            chk("t4_still_full", hit_ready, 0);
            chk("t4_ninth_held", hit_acc - acc0, 0);
            rf();
            wait_rd(5);
            chk("t3_fifth_latency", rd_cyc[4] - rf_cyc, 1);
            chk("t3_fifth_ssid", rd_ssid_log[4], 8'h34);
            rf();
            wait_rd(6);
            rf(); rf(); rf(); rf();
            wait_done(3);
         end
      join
      push_rd(8'h3f, 1);
      wait_rd(7);
      rf();
      wait_done(4);
      chk("t4_write_count", wr_cyc.size(), 10);
      chk("t4_ninth_written", wr_ssid[9], 8'h58);
      clear_logs();

      // Stray readFinished in IDLE
      rf();
      repeat (2) tick();
      chk("t5_credit_err", credit_err, 1);
      push_hit(8'h61, 8'h01, 1);
      push_rd(8'h61, 1);
      wait_rd(1);
      rf();
      wait_done(5);
      chk("t5_credit_err_sticky", credit_err, 1);
      clear_logs();

      // Reset during DRAIN with two reads buffered
      push_hit(8'h71, 8'h02, 1);
      push_rd(8'h72, 0);
      push_rd(8'h73, 1);
      wait_wr(1);
      repeat (2) tick();
      chk("t6_in_drain", busy, 1);
      reset = 1'b1;
      tick();
      chk("t6_write", write, 0);
      chk("t6_read", read, 0);
      chk("t6_busy", busy, 0);
      chk("t6_hit_ready", hit_ready, 1);
      chk("t6_rd_ready", rd_ready, 1);
      repeat (2) tick();
      reset = 1'b0;
      repeat (15) tick();
      chk("t6_no_reads_after_abort", rd_cyc.size(), 0);
      chk("t6_idle", busy, 0);
      push_hit(8'h81, 8'h03, 1);
      push_rd(8'h82, 1);
      wait_rd(1);
      chk("t6_fresh_rssid", rd_ssid_log[0], 8'h82);
      rf();
      wait_done(6);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
